sm_mult_unit: RTL and testbench

- Sequential 8-bit sign-magnitude fractional multiplier (1 sign bit + 7 magnitude bits) using add-and-shift.
- Built from:
  - an accumulator register A (with carry bit A[7]);
  - a multiplier register Q;
  - a multiplicand register M;
  - an iteration counter;
  - a control FSM.
- Operands arrive serially on ibus. The 16-bit result is returned serially on obus, A first then Q, with fin marking the last word.

---
 rtl/sm_mult_unit_if.sv | 11 +
 rtl/sm_mult_unit.sv | 109 ++++++++++
 tb/tb_sm_mult_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_mult_unit_if.sv
// Operand/result handshake bundle for the sign-magnitude multiplier.
// The master drives bgn and ibus; the slave (multiplier) returns obus and fin.
interface sm_mult_unit_if;
   logic       bgn;
   logic [7:0] ibus;
   logic       fin;
   logic [7:0] obus;

   modport master (output bgn, output ibus, input fin, input obus);
   modport slave  (input bgn, input ibus, output fin, output obus);
endinterface

// File: rtl/sm_mult_unit.sv
// Sequential 8-bit sign-magnitude fractional multiplier (add-and-shift).
// Optional macro SM_ZERO_SIGN_FIX_EN: forces a positive sign on a zero product.
module sm_mult_unit #(
   parameter int CNT_W = 3
) (
   input  logic          clk,
   input  logic          rst_b,
   sm_mult_unit_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, LDM, LDQ, TEST, ADD, SHIFT, SIGN, OUTA, OUTQ
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   state_t           state, state_nxt;
   logic [7:0]       a_q, q_q, m_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sign_bit;

   // After the loop Q[0] holds the original multiplier sign bit.
`ifdef SM_ZERO_SIGN_FIX_EN
   always_comb begin
      sign_bit = q_q[0] ^ m_q[7];
      if ({a_q[6:0], q_q[7:1]} == 14'd0)
         sign_bit = 1'b0;
   end
`else
   always_comb begin
      sign_bit = q_q[0] ^ m_q[7];
   end
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.bgn) state_nxt = LDM;
         LDM:     state_nxt = LDQ;
         LDQ:     state_nxt = TEST;
         TEST: begin
            if (cnt_q == CNT_LAST)
               state_nxt = SIGN;
            else if (q_q[0])
               state_nxt = ADD;
            else
               state_nxt = SHIFT;
         end
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = TEST;
         SIGN:    state_nxt = OUTA;
         OUTA:    state_nxt = OUTQ;
         OUTQ:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         a_q   <= '0;
         q_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state)
            LDM: begin
               m_q   <= bus.ibus;
               a_q   <= '0;
               cnt_q <= '0;
            end
            LDQ: q_q <= bus.ibus;
            ADD: a_q <= {1'b0, a_q[6:0]} + {1'b0, m_q[6:0]};
            SHIFT: begin
               a_q   <= {1'b0, a_q[7:1]};
               q_q   <= {a_q[0], q_q[7:1]};
               cnt_q <= cnt_q + CNT_ONE;
            end
            SIGN: begin
               a_q[7] <= sign_bit;
               q_q[0] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Result words are only visible for one cycle each; the bus idles at zero.
   always_comb begin
      bus.obus = '0;
      bus.fin  = 1'b0;
      case (state)
         OUTA: bus.obus = a_q;
         OUTQ: begin
            bus.obus = q_q;
            bus.fin  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sm_mult_unit.sv
// Self-checking bench for sm_mult_unit against a plain-arithmetic product model.
// Honors SM_ZERO_SIGN_FIX_EN the same way the design does.
module tb_sm_mult_unit;

   logic clk;
   logic rst_b;
   int   errors = 0;
   int   checks = 0;

   sm_mult_unit_if bus ();

   sm_mult_unit #(.CNT_W(3)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] idle_obus;
      logic       idle_fin;
      logic [7:0] a_word;
      logic [7:0] q_word;
      int         lat;
      int         stray;
      bit         timeout;
   } obs_t;

   // Reference: signed fractional product from magnitudes and sign XOR.
   function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
      int unsigned mag;
      logic        s;
      mag = int'(x[6:0]) * int'(y[6:0]);
      s   = x[7] ^ y[7];
`ifdef SM_ZERO_SIGN_FIX_EN
      if (mag == 0) s = 1'b0;
`endif
      ref_prod = {s, 7'(mag >> 7), 7'(mag), 1'b0};
   endfunction

   function automatic int ref_lat(input logic [7:0] y);
      ref_lat = 20 + $countones(y[6:0]);
   endfunction

   // Drives one operation starting in IDLE and records what the bus showed.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                         input bit hold_bgn, output obs_t o);
      int         cyc;
      logic [7:0] prev_ob;
      bit         done;
      @(negedge clk);
      o.idle_obus = bus.obus;
      o.idle_fin  = bus.fin;
      bus.bgn  = 1'b1;
      bus.ibus = x;
      @(posedge clk);
      cyc = 0; prev_ob = '0; done = 0;
      o.stray = 0; o.timeout = 0; o.lat = 0; o.a_word = '0; o.q_word = '0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && !hold_bgn) bus.bgn = 1'b0;
         if (cyc == 2) bus.ibus = y;
         else if (cyc == 3) bus.ibus = 8'($urandom);
         if (bus.fin === 1'b1) begin
            o.q_word = bus.obus;
            o.a_word = prev_ob;
            o.lat    = cyc;
            done     = 1;
         end else begin
            if (cyc > 1 && prev_ob !== 8'h00) o.stray++;
            if (bus.fin !== 1'b0) o.stray++;
            prev_ob = bus.obus;
            if (cyc >= 40) begin
               o.timeout = 1;
               o.lat     = cyc;
               done      = 1;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_b    = 1'b0;
      bus.bgn  = 1'b0;
      bus.ibus = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.obus !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_obus: got %h expected 00", bus.obus);
      end
      checks++;
      if (bus.fin !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_fin: got %b expected 0", bus.fin);
      end
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.obus !== 8'h00 || bus.fin !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got obus=%h fin=%b expected 00/0", bus.obus, bus.fin);
      end
   endtask

   task automatic test_directed();
      logic [7:0] xs [6] = '{8'h97, 8'h17, 8'h7F, 8'h80, 8'h55, 8'h05};
      logic [7:0] ys [6] = '{8'h83, 8'h83, 8'hFF, 8'h05, 8'h00, 8'h80};
      obs_t       o;
      logic [15:0] exp;
      for (int i = 0; i < 6; i++) begin
         run_op(xs[i], ys[i], 1'b0, o);
         exp = ref_prod(xs[i], ys[i]);
         checks++;
         if (o.timeout || o.lat !== ref_lat(ys[i])) begin
            errors++;
            $display("[TB] FAIL dir_latency x=%h y=%h: got %0d expected %0d", xs[i], ys[i], o.lat, ref_lat(ys[i]));
         end
         checks++;
         if (o.a_word !== exp[15:8]) begin
            errors++;
            $display("[TB] FAIL dir_a_word x=%h y=%h: got %h expected %h", xs[i], ys[i], o.a_word, exp[15:8]);
         end
         checks++;
         if (o.q_word !== exp[7:0]) begin
            errors++;
            $display("[TB] FAIL dir_q_word x=%h y=%h: got %h expected %h", xs[i], ys[i], o.q_word, exp[7:0]);
         end
         checks++;
         if (o.stray !== 0 || o.idle_obus !== 8'h00 || o.idle_fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dir_quiet_bus x=%h y=%h: got stray=%0d idle=%h/%b expected 0 00/0", xs[i], ys[i], o.stray, o.idle_obus, o.idle_fin);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  x, y;
      logic [15:0] exp;
      obs_t        o;
      for (int i = 0; i < 30; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         run_op(x, y, 1'b0, o);
         exp = ref_prod(x, y);
         checks++;
         if (o.timeout || o.lat !== ref_lat(y)) begin
            errors++;
            $display("[TB] FAIL rnd_latency x=%h y=%h: got %0d expected %0d", x, y, o.lat, ref_lat(y));
         end
         checks++;
         if ({o.a_word, o.q_word} !== exp) begin
            errors++;
            $display("[TB] FAIL rnd_result x=%h y=%h: got %h expected %h", x, y, {o.a_word, o.q_word}, exp);
         end
         checks++;
         if (o.stray !== 0) begin
            errors++;
            $display("[TB] FAIL rnd_quiet_bus x=%h y=%h: got %0d stray cycles expected 0", x, y, o.stray);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      @(negedge clk);
      bus.bgn  = 1'b1;
      bus.ibus = 8'h7F;
      @(negedge clk);
      bus.bgn  = 1'b0;
      @(negedge clk);
      bus.ibus = 8'hFF;
      repeat (8) @(negedge clk);
      rst_b = 1'b0;
      #1;
      checks++;
      if (bus.obus !== 8'h00 || bus.fin !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_async: got obus=%h fin=%b expected 00/0", bus.obus, bus.fin);
      end
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      repeat (30) begin
         @(negedge clk);
         checks++;
         if (bus.obus !== 8'h00 || bus.fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_output: got obus=%h fin=%b expected 00/0", bus.obus, bus.fin);
         end
      end
      run_op(8'h97, 8'h83, 1'b0, o);
      checks++;
      if (o.timeout || o.lat !== 22) begin
         errors++;
         $display("[TB] FAIL post_reset_latency: got %0d expected 22", o.lat);
      end
      checks++;
      if (o.a_word !== 8'h00 || o.q_word !== 8'h8A) begin
         errors++;
         $display("[TB] FAIL post_reset_result: got %h/%h expected 00/8a", o.a_word, o.q_word);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  x, y;
      logic [15:0] exp;
      obs_t        o;
      for (int i = 0; i < 5; i++) begin
         x = 8'($urandom);
         y = (i == 0) ? 8'h00 : 8'($urandom);
         run_op(x, y, (i != 4), o);
         exp = ref_prod(x, y);
         checks++;
         if (o.timeout || o.lat !== ref_lat(y)) begin
            errors++;
            $display("[TB] FAIL b2b_latency x=%h y=%h: got %0d expected %0d", x, y, o.lat, ref_lat(y));
         end
         checks++;
         if ({o.a_word, o.q_word} !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_result x=%h y=%h: got %h expected %h", x, y, {o.a_word, o.q_word}, exp);
         end
         checks++;
         if (o.stray !== 0 || o.idle_obus !== 8'h00 || o.idle_fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_gap x=%h y=%h: got stray=%0d idle=%h/%b expected 0 00/0", x, y, o.stray, o.idle_obus, o.idle_fin);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.fin !== 1'b0 || bus.obus !== 8'h00) begin
         errors++;
         $display("[TB] FAIL b2b_fin_width: got fin=%b obus=%h expected 0/00", bus.fin, bus.obus);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
